// File: rtl/addn_seq_if.sv
// ============================================================================
// Module      : addn_seq_if
// Description : Operand/result handshake bundle for the addn_seq
//               multi-cycle adder/subtractor.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface addn_seq_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  // Producer of operands / consumer of results.
  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  // The arithmetic block itself.
  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface

`default_nettype wire

// File: rtl/addn_seq.sv
// ============================================================================
// Module      : addn_seq
// Description : Multi-cycle WIDTH-bit adder/subtractor, CHUNK bits per cycle,
//               valid/ready handshake on operand and result sides.
//               Optional macro ADDN_SAT_EN: clamp sum to signed max/min on
//               signed overflow (cout/ovf unchanged).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module addn_seq #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  wire         clk,
  input  wire         rst_n,
  addn_seq_if.slave   bus
);

  localparam int N     = WIDTH / CHUNK;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam int MSB   = WIDTH - 1;

  // Reject illegal geometries at elaboration time.
  if ((WIDTH % CHUNK) != 0) begin : g_bad_chunk
    $error("addn_seq: WIDTH (%0d) must be a multiple of CHUNK (%0d)", WIDTH, CHUNK);
  end
  if (WIDTH < 2) begin : g_bad_width
    $error("addn_seq: WIDTH (%0d) must be at least 2", WIDTH);
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;       // already inverted for subtraction
  logic               carry_q, carry_d;
  logic [WIDTH-1:0]   acc_q, acc_d;   // raw result being assembled
  logic [WIDTH-1:0]   sum_q, sum_d;   // published result, held between ops
  logic               cout_q, cout_d;
  logic               ovf_q, ovf_d;

  logic [CHUNK-1:0]   a_chunk;
  logic [CHUNK-1:0]   b_chunk;
  logic [CHUNK:0]     chunk_sum;
  logic               last_chunk;
  logic               ovf_w;

  // Select the operand slice addressed by the chunk index.
  always_comb begin
    a_chunk = '0;
    b_chunk = '0;
    for (int i = 0; i < N; i++) begin
      if (idx_q == IDX_W'(i)) begin
        a_chunk = a_q[i*CHUNK +: CHUNK];
        b_chunk = b_q[i*CHUNK +: CHUNK];
      end
    end
    chunk_sum  = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry_q};
    last_chunk = (idx_q == IDX_W'(N - 1));
  end

  // Next-state, datapath update and flag generation.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    ovf_w   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.a;
          b_d     = bus.sub ? ~bus.b : bus.b;
          carry_d = bus.sub ? ~bus.cin : bus.cin;
          idx_d   = '0;
          acc_d   = '0;
          state_d = S_RUN;
        end
      end

      S_RUN: begin
        carry_d = chunk_sum[CHUNK];
        for (int i = 0; i < N; i++) begin
          if (idx_q == IDX_W'(i)) begin
            acc_d[i*CHUNK +: CHUNK] = chunk_sum[CHUNK-1:0];
          end
        end
        idx_d = idx_q + IDX_W'(1);
        if (last_chunk) begin
          idx_d   = '0;
          state_d = S_DONE;
          ovf_w   = (a_q[MSB] == b_q[MSB]) && (acc_d[MSB] != a_q[MSB]);
          cout_d  = chunk_sum[CHUNK];
          ovf_d   = ovf_w;
`ifdef ADDN_SAT_EN
          if (ovf_w) begin
            sum_d = a_q[MSB] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
          end else begin
            sum_d = acc_d;
          end
`else
          sum_d = acc_d;
`endif
        end
      end

      S_DONE: begin
        if (bus.out_ready) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      acc_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;

endmodule

`default_nettype wire
